// File: rtl/axin_dropfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axin_dropfifo_pkg
// Purpose  : Shared beat layout, width derivation and constants for the
//            AXI-network store-and-forward drop FIFO.
// Revision : 1.0
// ============================================================================
package axin_dropfifo_pkg;

    localparam int c_dw_default = 64;

    function automatic int axin_wbits(input int dw);
        return $clog2(dw / 8);
    endfunction

    localparam int c_wbits_default = axin_wbits(c_dw_default);

    localparam logic [31:0] c_cnt_sat = 32'hFFFF_FFFF;

    // Memory word layout: {last, bytes, data}
    typedef struct packed {
        logic                       last;
        logic [c_wbits_default-1:0] bytes;
        logic [c_dw_default-1:0]    data;
    } axin_beat_t;

endpackage
`default_nettype wire

// File: rtl/axin_dropfifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : axin_dropfifo_mem
// Purpose  : Simple dual-port RAM, one write port and one registered read port.
// Revision : 1.0
// ============================================================================
module axin_dropfifo_mem #(
    parameter int AW    = 9,
    parameter int WIDTH = 68
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register only advances on a load, so the output holds under back-pressure
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/axin_dropfifo.sv
`default_nettype none
// ============================================================================
// Module   : axin_dropfifo
// Purpose  : Store-and-forward packet FIFO that discards aborted and
//            overflowing packets, with saturating drop/abort counters.
// Revision : 1.0
// ============================================================================
module axin_dropfifo
    import axin_dropfifo_pkg::*;
#(
    parameter int DW           = c_dw_default,
    parameter int WBITS        = axin_wbits(DW),
    parameter int LGFLEN       = 9,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [DW-1:0]    S_DATA,
    input  logic [WBITS-1:0] S_BYTES,
    input  logic             S_LAST,
    input  logic             S_ABORT,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [DW-1:0]    M_DATA,
    output logic [WBITS-1:0] M_BYTES,
    output logic             M_LAST,
    output logic             M_ABORT,
    output logic [31:0]      o_drops,
    output logic [31:0]      o_aborts
);

    localparam int              c_bw      = DW + WBITS + 1;
    localparam logic [LGFLEN:0] c_depth   = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [LGFLEN:0] c_one     = {{LGFLEN{1'b0}}, 1'b1};
    localparam logic [0:0]      c_st_fill = 1'b0;
    localparam logic [0:0]      c_st_drop = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [LGFLEN:0] r_wr_addr;
    logic [LGFLEN:0] r_wr_commit;
    logic [LGFLEN:0] r_commit_vis;
    logic [LGFLEN:0] r_rd_addr;
    logic            w_full;
    logic            w_empty;
    logic            w_load;
    logic            w_wr_en;
    logic            w_rewind;
    logic            w_commit;
    logic            w_inc_drop;
    logic            w_inc_abort;
    logic            r_m_valid;
    logic [31:0]     r_drops;
    logic [31:0]     r_aborts;
    logic [c_bw-1:0] w_wr_beat;
    logic [c_bw-1:0] w_rd_beat;
    logic [c_bw-1:0] w_out_beat;

    assign w_full  = ((r_wr_addr - r_rd_addr) == c_depth);
    // Reads compare against a delayed copy of the commit pointer
    assign w_empty = (r_rd_addr == r_commit_vis);
    assign w_load  = (!r_m_valid || M_READY) && !w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= c_st_fill;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_fill: begin
                if (S_VALID && !S_ABORT && w_full && !S_LAST) begin
                    w_state_nxt = c_st_drop;
                end
            end
            c_st_drop: begin
                if (S_ABORT || (S_VALID && S_LAST)) begin
                    w_state_nxt = c_st_fill;
                end
            end
            default: w_state_nxt = c_st_fill;
        endcase
    end

    always_comb begin
        w_wr_en     = 1'b0;
        w_rewind    = 1'b0;
        w_commit    = 1'b0;
        w_inc_drop  = 1'b0;
        w_inc_abort = 1'b0;
        case (r_state)
            c_st_fill: begin
                if (S_ABORT) begin
                    w_rewind    = 1'b1;
                    w_inc_abort = S_VALID || (r_wr_addr != r_wr_commit);
                end else if (S_VALID && !w_full) begin
                    w_wr_en  = 1'b1;
                    w_commit = S_LAST;
                end else if (S_VALID) begin
                    w_rewind   = 1'b1;
                    w_inc_drop = S_LAST;
                end
            end
            c_st_drop: begin
                w_inc_drop = S_VALID && S_LAST && !S_ABORT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_addr    <= '0;
            r_wr_commit  <= '0;
            r_commit_vis <= '0;
            r_rd_addr    <= '0;
        end else begin
            if (w_rewind) begin
                r_wr_addr <= r_wr_commit;
            end else if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + c_one;
            end
            if (w_commit) begin
                r_wr_commit <= r_wr_addr + c_one;
            end
            r_commit_vis <= r_wr_commit;
            if (w_load) begin
                r_rd_addr <= r_rd_addr + c_one;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_m_valid <= 1'b0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
        end else if (M_READY) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_drops  <= '0;
            r_aborts <= '0;
        end else begin
            if (w_inc_drop && (r_drops != c_cnt_sat)) begin
                r_drops <= r_drops + 32'd1;
            end
            if (w_inc_abort && (r_aborts != c_cnt_sat)) begin
                r_aborts <= r_aborts + 32'd1;
            end
        end
    end

    assign w_wr_beat = {S_LAST, S_BYTES, S_DATA};

    axin_dropfifo_mem #(
        .AW    (LGFLEN),
        .WIDTH (c_bw)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_addr[LGFLEN-1:0]),
        .i_wr_data (w_wr_beat),
        .i_rd_en   (w_load),
        .i_rd_addr (r_rd_addr[LGFLEN-1:0]),
        .o_rd_data (w_rd_beat)
    );

    generate
        if (OPT_LOWPOWER) begin : g_lowpower
            assign w_out_beat = r_m_valid ? w_rd_beat : '0;
        end else begin : g_passthru
            assign w_out_beat = w_rd_beat;
        end
    endgenerate

    assign S_READY  = i_reset_n;
    assign M_VALID  = r_m_valid;
    assign M_LAST   = w_out_beat[DW+WBITS];
    assign M_BYTES  = w_out_beat[DW +: WBITS];
    assign M_DATA   = w_out_beat[DW-1:0];
    assign M_ABORT  = 1'b0;
    assign o_drops  = r_drops;
    assign o_aborts = r_aborts;

endmodule
`default_nettype wire
